// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_if
// Brief    : Fetch-stage bundle: imem request/response, redirect, decode side.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fetch_misaligned;
`endif

  modport master (
`ifdef FETCH_MISALIGN_CHECK_EN
    output fetch_misaligned,
`endif
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect, redirect_target,
    output instr_valid, instr, instr_pc, instr_pc_plus4,
    input  instr_ready
  );

  modport slave (
`ifdef FETCH_MISALIGN_CHECK_EN
    input  fetch_misaligned,
`endif
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect, redirect_target,
    input  instr_valid, instr, instr_pc, instr_pc_plus4,
    output instr_ready
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Credit-based in-order instruction fetch with redirect/discard.
//            Optional macro FETCH_MISALIGN_CHECK_EN traps misaligned targets.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);
  localparam int              c_aw    = $clog2(BUF_DEPTH);
  localparam int              c_cw    = c_aw + 1;
  localparam logic [c_cw:0]   c_limit = (c_cw + 1)'(BUF_DEPTH);

  logic [31:0]     r_pc;
  logic [c_cw-1:0] r_inflight;
  logic [c_cw-1:0] r_discard;
  logic [c_cw-1:0] r_count;
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_tag_rd;
  logic [c_aw-1:0] r_tag_wr;
  logic [31:0]     r_fifo_data [BUF_DEPTH];
  logic [31:0]     r_fifo_pc   [BUF_DEPTH];
  logic [31:0]     r_tag       [BUF_DEPTH];

  logic        w_credit;
  logic        w_req_valid;
  logic        w_accept;
  logic        w_head_valid;
  logic        w_pop;
  logic        w_rsp_keep;
  logic        w_rsp_drop;
  logic [31:0] w_target;

  // Outstanding plus buffered never exceeds the FIFO size, so responses always fit.
  assign w_credit = ({1'b0, r_inflight} + {1'b0, r_count}) < c_limit;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_misaligned;
  logic w_misalign;
  assign w_target    = bus.redirect_target;
  assign w_misalign  = (bus.redirect_target[1:0] != 2'b00);
  assign w_req_valid = rst_n & w_credit & ~bus.redirect & ~r_misaligned;
  assign bus.fetch_misaligned = r_misaligned;
`else
  assign w_target    = bus.redirect_target & 32'hFFFF_FFFC;
  assign w_req_valid = rst_n & w_credit & ~bus.redirect;
`endif

  assign w_accept     = w_req_valid & bus.imem_req_ready;
  assign w_head_valid = (r_count != '0);
  assign w_pop        = w_head_valid & bus.instr_ready;
  assign w_rsp_keep   = bus.imem_rsp_valid & ~bus.redirect & (r_discard == '0);
  assign w_rsp_drop   = bus.imem_rsp_valid & ~bus.redirect & (r_discard != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_inflight <= '0;
      r_discard  <= '0;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_tag_rd   <= '0;
      r_tag_wr   <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      r_misaligned <= 1'b0;
`endif
    end else begin
      r_inflight <= r_inflight + c_cw'(w_accept) - c_cw'(bus.imem_rsp_valid);
      if (bus.redirect) begin
        // Everything still outstanding is wrong-path, except a response landing now.
        r_pc      <= w_target;
        r_discard <= r_inflight - c_cw'(bus.imem_rsp_valid);
        r_count   <= '0;
        r_rd_ptr  <= '0;
        r_wr_ptr  <= '0;
        r_tag_rd  <= '0;
        r_tag_wr  <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
        if (w_misalign) begin
          r_misaligned <= 1'b1;
        end
`endif
      end else begin
        if (w_accept) begin
          r_pc     <= r_pc + 32'd4;
          r_tag_wr <= r_tag_wr + c_aw'(1);
        end
        if (w_rsp_keep) begin
          r_wr_ptr <= r_wr_ptr + c_aw'(1);
          r_tag_rd <= r_tag_rd + c_aw'(1);
        end
        if (w_rsp_drop) begin
          r_discard <= r_discard - c_cw'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + c_aw'(1);
        end
        r_count <= r_count + c_cw'(w_rsp_keep) - c_cw'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_tag[r_tag_wr] <= r_pc;
    end
    if (w_rsp_keep) begin
      r_fifo_data[r_wr_ptr] <= bus.imem_rsp_data;
      r_fifo_pc[r_wr_ptr]   <= r_tag[r_tag_rd];
    end
  end

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_pc;
  assign bus.instr_valid    = w_head_valid;
  assign bus.instr          = w_head_valid ? r_fifo_data[r_rd_ptr] : 32'h0;
  assign bus.instr_pc       = w_head_valid ? r_fifo_pc[r_rd_ptr] : 32'h0;
  assign bus.instr_pc_plus4 = w_head_valid ? (r_fifo_pc[r_rd_ptr] + 32'd4) : 32'h0;
endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Directed plus random checks of fetch_unit against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } req_t;

  req_t        memq[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          last_due = 0;
  int          buffered = 0;
  int          n_accept = 0;
  int          lat_lo   = 1;
  int          lat_hi   = 1;
  int          n0;
  logic [31:0] exp_req;
  logic [31:0] exp_pop;
  logic [31:0] first_pop;
  bit          blocked;
  bit          watch_pop;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs at the falling edge, check, then advance the model.
  task automatic tick(input bit redir, input logic [31:0] tgt, input bit drdy, input bit mrdy);
    bit   rsp;
    bit   exp_rv;
    req_t e;
    int   due;
    @(negedge clk);
    rsp = (memq.size() > 0) && (memq[0].due <= cyc);
    bus.imem_rsp_valid  = rsp;
    bus.imem_rsp_data   = rsp ? mem_word(memq[0].addr) : 32'h0;
    bus.redirect        = redir;
    bus.redirect_target = tgt;
    bus.instr_ready     = drdy;
    bus.imem_req_ready  = mrdy;
    #1;
    exp_rv = ((memq.size() + buffered) < 2) && !redir && !blocked;
    chk("req_valid", bus.imem_req_valid, exp_rv);
    chk("instr_valid", bus.instr_valid, buffered > 0);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("fetch_misaligned", bus.fetch_misaligned, blocked);
`endif
    if (buffered > 0 && drdy) begin
      chk("instr_pc", bus.instr_pc, exp_pop);
      chk("instr", bus.instr, mem_word(exp_pop));
      chk("instr_pc_plus4", bus.instr_pc_plus4, exp_pop + 32'd4);
      if (watch_pop) begin
        first_pop = bus.instr_pc;
        watch_pop = 1'b0;
      end
      exp_pop += 32'd4;
      buffered--;
    end
    if (rsp) begin
      e = memq.pop_front();
      if (!e.stale && !redir) buffered++;
    end
    if (redir) begin
      foreach (memq[i]) memq[i].stale = 1'b1;
      buffered = 0;
`ifdef FETCH_MISALIGN_CHECK_EN
      exp_req = tgt;
      if (tgt[1:0] != 2'b00) blocked = 1'b1;
`else
      exp_req = {tgt[31:2], 2'b00};
`endif
      exp_pop = exp_req;
    end else if (exp_rv && mrdy) begin
      chk("req_addr", bus.imem_req_addr, exp_req);
      due = cyc + $urandom_range(lat_hi, lat_lo);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      e.addr  = exp_req;
      e.due   = due;
      e.stale = 1'b0;
      memq.push_back(e);
      exp_req += 32'd4;
      n_accept++;
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n               = 1'b0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_rsp_valid  = 1'b0;
    bus.imem_rsp_data   = 32'h0;
    bus.redirect        = 1'b0;
    bus.redirect_target = 32'h0;
    bus.instr_ready     = 1'b0;
    #1;
    chk("rst_req_valid", bus.imem_req_valid, 32'h0);
    chk("rst_instr_valid", bus.instr_valid, 32'h0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_instr_pc", bus.instr_pc, 32'h0);
    chk("rst_instr_pc_plus4", bus.instr_pc_plus4, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("rst_fetch_misaligned", bus.fetch_misaligned, 32'h0);
`endif
    memq.delete();
    buffered  = 0;
    exp_req   = 32'h0;
    exp_pop   = 32'h0;
    blocked   = 1'b0;
    watch_pop = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_rsp_valid  = 1'b0;
    bus.imem_rsp_data   = 32'h0;
    bus.redirect        = 1'b0;
    bus.redirect_target = 32'h0;
    bus.instr_ready     = 1'b0;

    // Streaming, latency 1, decode always ready
    do_reset();
    repeat (20) tick(1'b0, 32'h0, 1'b1, 1'b1);

    // Decode stalled: exactly two fetches, head holds PC 0
    do_reset();
    n0 = n_accept;
    repeat (10) tick(1'b0, 32'h0, 1'b0, 1'b1);
    chk("stall_req_count", n_accept - n0, 32'd2);
    chk("stall_req_valid", bus.imem_req_valid, 32'h0);
    chk("stall_head_pc", bus.instr_pc, 32'h0);
    repeat (10) tick(1'b0, 32'h0, 1'b1, 1'b1);

    // Latency 3, redirect with two in flight
    do_reset();
    lat_lo = 3;
    lat_hi = 3;
    repeat (4) tick(1'b0, 32'h0, 1'b1, 1'b1);
    for (int k = 0; k < 40 && memq.size() != 2; k++) tick(1'b0, 32'h0, 1'b1, 1'b1);
    watch_pop = 1'b1;
    first_pop = 32'hDEAD_DEAD;
    tick(1'b1, 32'h0000_0100, 1'b1, 1'b1);
    repeat (12) tick(1'b0, 32'h0, 1'b1, 1'b1);
    chk("redirect_first_pc", first_pop, 32'h0000_0100);

    // Redirect coinciding with a response and a decode handshake
    lat_lo = 1;
    lat_hi = 1;
    for (int k = 0; k < 40 && !(memq.size() > 0 && memq[0].due <= cyc && buffered > 0); k++)
      tick(1'b0, 32'h0, 1'b1, 1'b1);
    tick(1'b1, 32'h0000_0040, 1'b1, 1'b1);
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    repeat (6) tick(1'b0, 32'h0, 1'b1, 1'b1);

    // PC wrap at 2^32
    tick(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
    repeat (8) tick(1'b0, 32'h0, 1'b1, 1'b1);

    // Misaligned target
    tick(1'b1, 32'h0000_0202, 1'b1, 1'b1);
    repeat (8) tick(1'b0, 32'h0, 1'b1, 1'b1);

    // Reset mid-operation, then random traffic
    do_reset();
    lat_lo = 1;
    lat_hi = 4;
    for (int i = 0; i < 1500; i++) begin
      if (i == 750) do_reset();
      tick($urandom_range(0, 19) == 0, $urandom & 32'hFFFF_FFFC,
           $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
